// File: rtl/ppm_frame_decoder.sv
// PPM receive demodulator: preamble lock, per-symbol slot timing, packet
// reassembly and an avail/read handoff of the packet or a frame error.
module ppm_frame_decoder #(
    parameter int PULSE_CT = 7500,
    parameter int N_MOD    = 2,
    parameter int L        = 15000,
    parameter int N_PKT    = 48,
    parameter int PRE_CT   = 4,
    parameter int DELTA    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse,
    input  logic             read,
    output logic [N_PKT-1:0] data,
    output logic             avail,
    output logic             error
);

    localparam int NSLOT = 2 ** N_MOD;
    localparam int SLOT  = L / NSLOT;
    localparam int N_SYM = N_PKT / N_MOD;
    localparam int TW    = $clog2(N_SYM * L + L + DELTA + 1);
    localparam int MAXO  = (NSLOT - 1) * SLOT + DELTA;
    localparam int PW    = $clog2(PRE_CT + 1);
    localparam int SW    = $clog2(N_SYM + 1);

    // Reject parameter sets where slot neighbourhoods overlap or the
    // tolerance exceeds the pulse width.
    if ((L % NSLOT) != 0 || (N_PKT % N_MOD) != 0 ||
        DELTA >= SLOT / 2 || DELTA >= PULSE_CT) begin : g_bad_params
        $error("ppm_frame_decoder: inconsistent parameters");
    end

    typedef enum logic [1:0] {IDLE, PRE, DATA, HOLD} state_t;

    state_t           state_q, state_d;
    logic [2:0]       sync_q, sync_d;
    logic [TW-1:0]    t_q, t_d;
    logic [TW-1:0]    win_q, win_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [SW-1:0]    sym_q, sym_d;
    logic [N_PKT-1:0] shreg_q, shreg_d;
    logic [N_PKT-1:0] data_q, data_d;
    logic             avail_q, avail_d;
    logic             error_q, error_d;

    logic             rise;
    logic             hit;
    logic [N_MOD-1:0] hit_v;
    logic             pre_ok;
    logic             pre_tmo;
    logic             data_tmo;

    // Two synchroniser stages plus a history bit for rising-edge detection.
    always_comb sync_d = {sync_q[1:0], pulse};

    assign rise = sync_q[1] & ~sync_q[2];

    // Timer windows: preamble spacing, data slot match and data timeout.
    // t_q counts cycles since the reference edge; win_q is the nominal
    // start of the current symbol window on the same time base.
    always_comb begin
        hit      = 1'b0;
        hit_v    = '0;
        pre_ok   = (int'(t_q) >= L - DELTA) && (int'(t_q) <= L + DELTA);
        pre_tmo  = int'(t_q) > L + DELTA;
        data_tmo = int'(t_q) > int'(win_q) + MAXO;
        for (int v = 0; v < NSLOT; v++) begin
            if (int'(t_q) >= int'(win_q) + v * SLOT - DELTA &&
                int'(t_q) <= int'(win_q) + v * SLOT + DELTA) begin
                hit   = 1'b1;
                hit_v = N_MOD'(v);
            end
        end
    end

    // Next-state and output logic of the frame FSM.
    always_comb begin
        state_d = state_q;
        t_d     = (t_q == '1) ? t_q : t_q + 1'b1;
        win_d   = win_q;
        pre_d   = pre_q;
        sym_d   = sym_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        avail_d = avail_q;
        error_d = error_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRE;
                    t_d     = TW'(1);
                    pre_d   = PW'(1);
                end
            end
            PRE: begin
                if (rise) begin
                    t_d = TW'(1);
                    if (!pre_ok) begin
                        pre_d = PW'(1);
                    end else if (int'(pre_q) == PRE_CT - 1) begin
                        state_d = DATA;
                        sym_d   = '0;
                        win_d   = TW'(L);
                        shreg_d = '0;
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end else if (pre_tmo) begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (rise && hit) begin
                    shreg_d = {shreg_q[N_PKT-N_MOD-1:0], hit_v};
                    sym_d   = sym_q + 1'b1;
                    win_d   = win_q + TW'(L);
                    if (int'(sym_q) == N_SYM - 1) begin
                        state_d = HOLD;
                        data_d  = {shreg_q[N_PKT-N_MOD-1:0], hit_v};
                        avail_d = 1'b1;
                        error_d = 1'b0;
                    end
                end else if (rise || data_tmo) begin
                    state_d = HOLD;
                    data_d  = '0;
                    avail_d = 1'b1;
                    error_d = 1'b1;
                end
            end
            HOLD: begin
                if (read) begin
                    state_d = IDLE;
                    avail_d = 1'b0;
                    error_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= '0;
            t_q     <= '0;
            win_q   <= '0;
            pre_q   <= '0;
            sym_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            avail_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            t_q     <= t_d;
            win_q   <= win_d;
            pre_q   <= pre_d;
            sym_q   <= sym_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            avail_q <= avail_d;
            error_q <= error_d;
        end
    end

    assign data  = data_q;
    assign avail = avail_q;
    assign error = error_q;

endmodule

// File: tb/tb_ppm_frame_decoder.sv
// Bench for ppm_frame_decoder: encoder model drives pulse from a schedule of
// rise times; a timestamp-based reference model predicts avail/error/data.
module tb_ppm_frame_decoder;

    localparam int PULSE_CT = 4;
    localparam int N_MOD    = 2;
    localparam int L        = 64;
    localparam int N_PKT    = 8;
    localparam int PRE_CT   = 4;
    localparam int DELTA    = 1;
    localparam int NSLOT    = 4;
    localparam int SLOT     = 16;
    localparam int N_SYM    = 4;
    localparam int MAXO     = (NSLOT - 1) * SLOT + DELTA;

    logic       clk = 1'b0;
    logic       rst;
    logic       pulse;
    logic       read;
    logic [7:0] data;
    logic       avail;
    logic       error;

    ppm_frame_decoder #(
        .PULSE_CT(PULSE_CT), .N_MOD(N_MOD), .L(L),
        .N_PKT(N_PKT), .PRE_CT(PRE_CT), .DELTA(DELTA)
    ) dut (
        .clk(clk), .rst(rst), .pulse(pulse), .read(read),
        .data(data), .avail(avail), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    int rise_q[$];
    int edge_q[$];
    int last_rise, anchor_rise;
    int sym_rise[4];

    // model state (absolute timestamps in clock cycles)
    int         m_mode = 0; // 0 idle, 1 preamble, 2 data, 3 holding
    int         m_last, m_pre, m_anchor, m_sym;
    logic [7:0] m_sh;
    logic [7:0] exp_data  = '0;
    logic       exp_avail = 1'b0;
    logic       exp_err   = 1'b0;

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    task automatic finish_frame(input logic err, input logic [7:0] d);
        m_mode    = 3;
        exp_avail = 1'b1;
        exp_err   = err;
        exp_data  = d;
    endtask

    // A pulse edge becomes visible to the decoder logic 3 cycles after rise.
    task automatic model_step();
        bit e;
        int dt, o, v;
        e = 1'b0;
        if (edge_q.size() > 0 && edge_q[0] == cyc) begin
            void'(edge_q.pop_front());
            e = 1'b1;
        end
        if (rst) begin
            m_mode = 0; exp_avail = 0; exp_err = 0; exp_data = '0;
            return;
        end
        case (m_mode)
            0: if (e) begin m_mode = 1; m_pre = 1; m_last = cyc; end
            1: begin
                dt = cyc - m_last;
                if (e) begin
                    if (dt >= L - DELTA && dt <= L + DELTA) begin
                        m_pre++;
                        m_last = cyc;
                        if (m_pre == PRE_CT) begin
                            m_mode = 2; m_anchor = cyc; m_sym = 0; m_sh = '0;
                        end
                    end else begin
                        m_pre = 1; m_last = cyc;
                    end
                end else if (dt > L + DELTA) m_mode = 0;
            end
            2: begin
                o = cyc - (m_anchor + (m_sym + 1) * L);
                if (e) begin
                    v = -1;
                    for (int s = 0; s < NSLOT; s++)
                        if (o >= s * SLOT - DELTA && o <= s * SLOT + DELTA) v = s;
                    if (v >= 0) begin
                        m_sh = 8'((int'(m_sh) << N_MOD) | v);
                        m_sym++;
                        if (m_sym == N_SYM) finish_frame(1'b0, m_sh);
                    end else finish_frame(1'b1, 8'h00);
                end else if (o > MAXO) finish_frame(1'b1, 8'h00);
            end
            default: if (read) begin m_mode = 0; exp_avail = 0; exp_err = 0; end
        endcase
    endtask

    // model advances on each active edge
    initial forever begin
        @(posedge clk);
        cyc++;
        model_step();
    end

    // encoder: rise at negedge when cyc matches, held PULSE_CT cycles
    initial begin
        int hi;
        hi = 0;
        pulse = 1'b0;
        forever begin
            @(negedge clk);
            while (rise_q.size() > 0 && rise_q[0] < cyc) void'(rise_q.pop_front());
            if (rise_q.size() > 0 && rise_q[0] == cyc) begin
                void'(rise_q.pop_front());
                hi = PULSE_CT;
                edge_q.push_back(cyc + 3);
            end
            pulse = (hi > 0);
            if (hi > 0) hi--;
        end
    end

    // every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            checks++;
            if (avail !== exp_avail || error !== exp_err || data !== exp_data) begin
                errors++;
                $display("FAIL model cycle %0d: avail=%b error=%b data=%h, expected avail=%b error=%b data=%h",
                         cyc, avail, error, data, exp_avail, exp_err, exp_data);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_read();
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic sched_frame(input int start, input logic [7:0] val,
                               input int j0, input int j1, input int j2, input int j3,
                               input int drop);
        int jit[4];
        int sv;
        jit = '{j0, j1, j2, j3};
        for (int i = 0; i < PRE_CT; i++) rise_q.push_back(start + i * L);
        anchor_rise = start + (PRE_CT - 1) * L;
        last_rise   = anchor_rise;
        for (int k = 0; k < N_SYM; k++) begin
            sv = (int'(val) >> (N_PKT - N_MOD * (k + 1))) & (NSLOT - 1);
            sym_rise[k] = anchor_rise + (k + 1) * L + sv * SLOT + jit[k];
            if (((drop >> k) & 1) == 0) begin
                rise_q.push_back(sym_rise[k]);
                last_rise = sym_rise[k];
            end
        end
    endtask

    task automatic clean_frame(input string nm, input logic [7:0] val);
        sched_frame(cyc + 4, val, 0, 0, 0, 0, 0);
        wait_until(last_rise + 3);
        chk({nm, " avail"}, int'(avail), 1);
        chk({nm, " error"}, int'(error), 0);
        chk({nm, " data"}, int'(data), int'(val));
    endtask

    initial begin
        int s, tmo, kind, k, endc;
        logic [7:0] val;
        int j[4];
        rst  = 1'b1;
        read = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset avail", int'(avail), 0);
        chk("reset error", int'(error), 0);
        chk("reset data", int'(data), 0);
        rst = 1'b0;

        // 1: clean frame, exact latency, read clears avail
        sched_frame(cyc + 4, 8'hB4, 0, 0, 0, 0, 0);
        wait_until(last_rise + 2);
        chk("t1 avail before latency", int'(avail), 0);
        wait_until(last_rise + 3);
        chk("t1 avail", int'(avail), 1);
        chk("t1 error", int'(error), 0);
        chk("t1 data", int'(data), 8'hB4);
        do_read();
        chk("t1 avail after read", int'(avail), 0);
        chk("t1 data kept after read", int'(data), 8'hB4);

        // 2: jitter +1 and -1 accepted, +2 rejected
        sched_frame(cyc + 4, 8'h1B, 1, 1, 1, 1, 0);
        wait_until(last_rise + 3);
        chk("t2 late data", int'(data), 8'h1B);
        chk("t2 late error", int'(error), 0);
        do_read();
        sched_frame(cyc + 4, 8'h1B, -1, -1, -1, -1, 0);
        wait_until(last_rise + 3);
        chk("t2 early data", int'(data), 8'h1B);
        chk("t2 early error", int'(error), 0);
        do_read();
        sched_frame(cyc + 4, 8'h1B, 0, 2, 0, 0, 0);
        wait_until(sym_rise[1] + 3);
        chk("t2 bad avail", int'(avail), 1);
        chk("t2 bad error", int'(error), 1);
        chk("t2 bad data", int'(data), 0);
        wait_until(last_rise + 10);
        do_read();

        // 3: missing third symbol -> timeout error, later edges ignored
        sched_frame(cyc + 4, 8'hE4, 0, 0, 0, 0, 4);
        tmo = anchor_rise + 3 + 3 * L + MAXO + 1;
        wait_until(tmo - 1);
        chk("t3 avail before timeout", int'(avail), 0);
        wait_until(tmo);
        chk("t3 timeout avail", int'(avail), 1);
        chk("t3 timeout error", int'(error), 1);
        chk("t3 timeout data", int'(data), 0);
        wait_until(last_rise + 10);
        chk("t3 held error", int'(error), 1);
        do_read();

        // 4: broken preamble then a valid frame
        s = cyc + 4;
        rise_q.push_back(s);
        rise_q.push_back(s + L);
        sched_frame(s + L + 80, 8'h5A, 0, 0, 0, 0, 0);
        wait_until(last_rise + 3);
        chk("t4 data", int'(data), 8'h5A);
        chk("t4 error", int'(error), 0);
        do_read();

        // 5: second frame dropped while holding, third decodes
        sched_frame(cyc + 4, 8'hC3, 0, 0, 0, 0, 0);
        sched_frame(last_rise + 40, 8'h3C, 0, 0, 0, 0, 0);
        wait_until(last_rise + 10);
        chk("t5 held data", int'(data), 8'hC3);
        chk("t5 held avail", int'(avail), 1);
        do_read();
        clean_frame("t5 third", 8'h3C);
        do_read();

        // 6: reset during symbol 2 aborts the frame
        sched_frame(cyc + 4, 8'h96, 0, 0, 0, 0, 12);
        wait_until(anchor_rise + 3 * L + 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6 reset avail", int'(avail), 0);
        chk("t6 reset error", int'(error), 0);
        chk("t6 reset data", int'(data), 0);
        clean_frame("t6 after reset", 8'h96);
        do_read();

        // randomized frames: jitter, bad slots, dropped symbols, stray reads
        for (int n = 0; n < 16; n++) begin
            val  = 8'($urandom);
            for (int i = 0; i < 4; i++) j[i] = int'($urandom_range(0, 2)) - 1;
            kind = int'($urandom_range(0, 3));
            k    = int'($urandom_range(0, 3));
            if (kind == 0) j[k] = ($urandom_range(0, 1) == 0) ? 2 : -2;
            s = cyc + 4 + int'($urandom_range(0, 30));
            sched_frame(s, val, j[0], j[1], j[2], j[3], (kind == 1) ? (1 << k) : 0);
            if (kind == 2) begin
                wait_until(s + L + 10);
                do_read();
            end
            endc = anchor_rise + 4 * L + 60;
            if (last_rise + 12 > endc) endc = last_rise + 12;
            wait_until(endc + int'($urandom_range(0, 5)));
            do_read();
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ppm_frame_decoder.md
Name: ppm_frame_decoder

Overview:
- Receive-side demodulator for the pulse-position-modulated (PPM) optical link. It is the counterpart of the Encoder that drives the `pulse` line.
- Detects the preamble, times each data symbol's pulse inside its symbol window, and reassembles an N_PKT-bit packet.
- Hands the packet, or a frame error, to the application layer (transmitter/receiver FSMs) through an avail/read handshake.

Parameters:
- PULSE_CT, 7500: encoder pulse high width in clk cycles. Informational only; the decoder uses rising edges.
- N_MOD, 2: bits per symbol. Each symbol window has 2**N_MOD slots.
- L, 15000: symbol period in clk cycles. SLOT = L / 2**N_MOD; L must be a multiple of 2**N_MOD.
- N_PKT, 48: packet width. Must be a multiple of N_MOD; N_SYM = N_PKT/N_MOD.
- PRE_CT, 4: preamble pulses per frame.
- DELTA, 1: timing tolerance in cycles. Must be < SLOT/2 and < PULSE_CT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pulse  in  1  asynchronous PPM line from the encoder
- read  in  1  consumer acknowledge; clears avail/error
- data  out  N_PKT  decoded packet, first symbol in the MSBs
- avail  out  1  packet or error ready, held until read
- error  out  1  frame error flag, valid while avail=1

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. rst=1 forces IDLE, data=0, avail=0, error=0, clears all counters and the synchroniser. Reset mid-frame discards the frame.
- Input edge detection:
  - pulse passes through a 2-FF synchroniser plus one history FF.
  - edge = sync2 & ~sync3.
  - All timing is measured edge to edge, so synchroniser latency cancels.
- Frame format:
  - PRE_CT rising edges spaced L apart.
  - Then N_SYM symbols. Symbol k has nominal window start S_k = (k+1)*L after the last preamble edge.
  - Symbol value v places its edge at S_k + v*SLOT.
- State IDLE: on edge, start timer t=0, set pre_cnt=1, go to PRE.
- State PRE:
  - Edge with t in [L-DELTA, L+DELTA]: pre_cnt++ and t=0. If pre_cnt reaches PRE_CT, go to DATA with sym=0 and timer t=0 at that edge.
  - Edge with t < L-DELTA: restart preamble with pre_cnt=1, t=0.
  - t > L+DELTA with no edge: go to IDLE. No error is reported.
- State DATA: the offset o of an edge from S_sym is signed, in [-DELTA, (2**N_MOD-1)*SLOT+DELTA].
  - If |o - v*SLOT| <= DELTA for some v: shift v into the shift register, MSB-first; sym++.
  - An edge outside every ±DELTA slot neighbourhood, or an edge before S_sym-DELTA, is a frame error.
  - A missing edge is a frame error. Timeout is when o exceeds (2**N_MOD-1)*SLOT+DELTA.
  - After symbol N_SYM-1 decodes, go to HOLD with data=shift register, avail=1, error=0.
  - On a frame error, go to HOLD with avail=1, error=1, data=0.
- State HOLD:
  - avail, error and data stay stable.
  - Pulse edges are ignored. Frames arriving in HOLD are dropped.
  - read=1 clears avail and error the next cycle and returns to IDLE. data keeps its last value.
  - read while not in HOLD has no effect.
- Latency: avail rises on the 3rd rising clk edge after the final symbol's pulse goes high at the port. For a timeout error, avail rises 1 cycle after the timeout point.
- Simultaneity:
  - read and rst together: rst wins.
  - An edge in the same cycle as the HOLD→IDLE transition is ignored. The preamble needs a fresh edge.
- Widths and overflow: the timer is $clog2(N_SYM*L+L+DELTA+1) bits and saturates; it never wraps.

Test Plan:
Common settings: L=64, N_MOD=2 (SLOT=16), PULSE_CT=4, PRE_CT=4, N_PKT=8, DELTA=1. A bench encoder model drives pulse.
1. Clean frame 8'hB4 (symbols 2,3,1,0) -> avail=1, error=0, data=8'hB4 three cycles after the last pulse rises; read=1 -> avail=0 next cycle.
2. Jitter: each data edge shifted +1, then -1 cycle, value 8'h1B -> data=8'h1B, error=0. A shift of +2 on symbol 1 -> avail=1, error=1, data=0.
3. Missing symbol: suppress the 3rd data pulse -> avail=1, error=1 at the timeout of window 2 (o = 48+1+1 cycles). No further edges are accepted until read.
4. Broken preamble: 2 preamble edges, then a gap of 80 cycles, then a full valid frame 8'h5A -> first attempt silently drops to IDLE; data=8'h5A, error=0.
5. Back-to-back frames 8'hC3 then 8'h3C, with read withheld until after the second frame -> data stays 8'hC3 and the second frame is dropped. After read, a third frame 8'h3C decodes correctly.
6. Reset mid-frame: assert rst for 1 cycle during symbol 2 -> avail=0, error=0, data=0 the cycle after. A subsequent clean frame 8'h96 decodes correctly.
